// File: rtl/bcd_digit_collector_if.sv
// Handshake bundle for bcd_digit_collector: the digit input stream and the
// four-nibble word output.
interface bcd_digit_collector_if;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       digit_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] c;
   logic [3:0] d;
   logic       word_valid;
   logic       word_ack;

   // master: producer of digits and consumer of words
   modport master (
      output digit_in, digit_valid, word_ack,
      input  digit_ready, a, b, c, d, word_valid
   );

   // slave: the collector itself
   modport slave (
      input  digit_in, digit_valid, word_ack,
      output digit_ready, a, b, c, d, word_valid
   );
endinterface

// File: rtl/bcd_digit_collector.sv
// Collects four BCD digits into a word and presents them as parallel nibbles.
// Optional partial-word idle timeout is built when BCD_TIMEOUT_EN is defined.
module bcd_digit_collector #(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bcd_digit_collector_if.slave bus,
   input  logic                 clear,
   output logic                 bcd_error,
   output logic [2:0]           digit_count,
   output logic                 timeout
);

   if (NUM_DIGITS != 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("bcd_digit_collector: NUM_DIGITS must be 4 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      COLLECT,
      PRESENT,
      ERROR
   } state_t;

   state_t                    state_q, state_d;
   logic [NUM_DIGITS-1:0][3:0] dbuf_q, dbuf_d;
   logic [2:0]                count_q, count_d;
   logic [3:0]                a_q, a_d;
   logic [3:0]                b_q, b_d;
   logic [3:0]                c_q, c_d;
   logic [3:0]                d_q, d_d;
   logic                      wv_q, wv_d;
   logic                      err_q, err_d;
   logic                      ready_q, ready_d;
   logic                      accept;

`ifdef BCD_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              timeout_q, timeout_d;
`endif

   assign accept = bus.digit_valid && ready_q;

   always_comb begin
      state_d = state_q;
      dbuf_d  = dbuf_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      wv_d    = wv_q;
      err_d   = err_q;
`ifdef BCD_TIMEOUT_EN
      idle_d    = idle_q;
      timeout_d = 1'b0;
`endif

      if (clear) begin
         state_d = COLLECT;
         dbuf_d  = '0;
         count_d = '0;
         wv_d    = 1'b0;
         err_d   = 1'b0;
`ifdef BCD_TIMEOUT_EN
         idle_d  = '0;
`endif
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
`ifdef BCD_TIMEOUT_EN
                  idle_d = '0;
`endif
                  if (bus.digit_in > 4'd9) begin
                     state_d = ERROR;
                     err_d   = 1'b1;
                     count_d = '0;
                     dbuf_d  = '0;
                  end else if (count_q == 3'(NUM_DIGITS - 1)) begin
                     // last digit bypasses the buffer straight into d
                     a_d     = dbuf_q[0];
                     b_d     = dbuf_q[1];
                     c_d     = dbuf_q[2];
                     d_d     = bus.digit_in;
                     wv_d    = 1'b1;
                     count_d = '0;
                     dbuf_d  = '0;
                     state_d = PRESENT;
                  end else begin
                     dbuf_d[count_q[1:0]] = bus.digit_in;
                     count_d              = count_q + 3'd1;
                  end
               end
`ifdef BCD_TIMEOUT_EN
               else if (count_q != 3'd0) begin
                  if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                     idle_d    = '0;
                     count_d   = '0;
                     dbuf_d    = '0;
                     timeout_d = 1'b1;
                  end else begin
                     idle_d = idle_q + 1'b1;
                  end
               end
`endif
            end
            PRESENT: begin
               if (bus.word_ack) begin
                  wv_d    = 1'b0;
                  state_d = COLLECT;
               end
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = COLLECT;
            end
         endcase
      end

      ready_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         dbuf_q  <= '0;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         wv_q    <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dbuf_q  <= dbuf_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         wv_q    <= wv_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

`ifdef BCD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign bus.digit_ready = ready_q;
   assign bus.a           = a_q;
   assign bus.b           = b_q;
   assign bus.c           = c_q;
   assign bus.d           = d_q;
   assign bus.word_valid  = wv_q;
   assign bcd_error       = err_q;
   assign digit_count     = count_q;

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Bench for bcd_digit_collector: directed scenarios plus randomized traffic
// checked against a queue-based word model.
module tb_bcd_digit_collector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       bcd_error;
   logic [2:0] digit_count;
   logic       timeout;

   bcd_digit_collector_if bus ();

   bcd_digit_collector #(
      .NUM_DIGITS     (4),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .clear       (clear),
      .bcd_error   (bcd_error),
      .digit_count (digit_count),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // model: digits of the partial word, presented word, flags
   int          m_part[$];
   logic [15:0] m_word = '0;
   bit          m_wv = 1'b0;
   bit          m_err = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_part.delete();
      m_word = '0;
      m_wv   = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic send(input logic [3:0] dg);
      for (int i = 0; i < 20 && bus.digit_ready !== 1'b1; i++) tick();
      if (bus.digit_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_wait: digit_ready=%b, required 1 within 20 cycles", bus.digit_ready);
         return;
      end
      bus.digit_in    = dg;
      bus.digit_valid = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
      if (dg > 9) begin
         m_part.delete();
         m_err = 1'b1;
      end else begin
         m_part.push_back(int'(dg));
         if (m_part.size() == 4) begin
            m_word = 16'(m_part[0] * 4096 + m_part[1] * 256 + m_part[2] * 16 + m_part[3]);
            m_wv   = 1'b1;
            m_part.delete();
         end
      end
   endtask

   task automatic ack();
      bus.word_ack = 1'b1;
      tick();
      bus.word_ack = 1'b0;
      m_wv = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_part.delete();
      m_wv  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      vectors++;
      if ({bus.a, bus.b, bus.c, bus.d, bus.word_valid, bcd_error, digit_count, timeout, bus.digit_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: abcd=%h wv=%b err=%b cnt=%0d to=%b rdy=%b, required all 0",
                  {bus.a, bus.b, bus.c, bus.d}, bus.word_valid, bcd_error, digit_count, timeout, bus.digit_ready);
      end
      rst_n = 1'b1;
      vectors++;
      if (bus.digit_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready_low: digit_ready=%b, required 0 before first edge", bus.digit_ready);
      end
      tick();
      vectors++;
      if (bus.digit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready_rise: digit_ready=%b, required 1", bus.digit_ready);
      end
   endtask

   task automatic test_word_assembly();
      send(4'd1);
      send(4'd2);
      send(4'd3);
      send(4'd6);
      vectors++;
      if ({bus.word_valid, bus.digit_ready, bus.a, bus.b, bus.c, bus.d} !== {2'b10, 16'h1236}) begin
         miscompares++;
         $display("FAIL assembly_word: wv=%b rdy=%b abcd=%h, required wv=1 rdy=0 abcd=1236",
                  bus.word_valid, bus.digit_ready, {bus.a, bus.b, bus.c, bus.d});
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({bus.word_valid, bus.digit_ready, bus.a, bus.b, bus.c, bus.d} !== {2'b10, 16'h1236}) begin
            miscompares++;
            $display("FAIL assembly_hold: cycle %0d wv=%b rdy=%b abcd=%h, required wv=1 rdy=0 abcd=1236",
                     i, bus.word_valid, bus.digit_ready, {bus.a, bus.b, bus.c, bus.d});
         end
      end
      ack();
      vectors++;
      if ({bus.word_valid, bus.digit_ready, bus.a, bus.b, bus.c, bus.d} !== {2'b01, 16'h1236}) begin
         miscompares++;
         $display("FAIL assembly_ack: wv=%b rdy=%b abcd=%h, required wv=0 rdy=1 abcd=1236",
                  bus.word_valid, bus.digit_ready, {bus.a, bus.b, bus.c, bus.d});
      end
   endtask

   task automatic test_backpressure();
      send(4'd4);
      send(4'd0);
      send(4'd8);
      send(4'd1);
      bus.digit_in    = 4'd7;
      bus.digit_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({bus.digit_ready, digit_count, bus.a, bus.b, bus.c, bus.d} !== {1'b0, 3'd0, 16'h4081}) begin
            miscompares++;
            $display("FAIL backpressure_hold: rdy=%b cnt=%0d abcd=%h, required rdy=0 cnt=0 abcd=4081",
                     bus.digit_ready, digit_count, {bus.a, bus.b, bus.c, bus.d});
         end
      end
      ack();
      bus.digit_valid = 1'b0;
      vectors++;
      if ({bus.word_valid, digit_count, bus.a, bus.b, bus.c, bus.d} !== {1'b0, 3'd0, 16'h4081}) begin
         miscompares++;
         $display("FAIL backpressure_ack: wv=%b cnt=%0d abcd=%h, required wv=0 cnt=0 abcd=4081",
                  bus.word_valid, digit_count, {bus.a, bus.b, bus.c, bus.d});
      end
      for (int i = 0; i < 4; i++) send(4'd9);
      vectors++;
      if ({bus.word_valid, bus.a, bus.b, bus.c, bus.d} !== {1'b1, 16'h9999}) begin
         miscompares++;
         $display("FAIL backpressure_9999: wv=%b abcd=%h, required wv=1 abcd=9999",
                  bus.word_valid, {bus.a, bus.b, bus.c, bus.d});
      end
      ack();
   endtask

   task automatic test_bcd_error();
      send(4'd4);
      send(4'd5);
      send(4'hA);
      vectors++;
      if ({bcd_error, bus.digit_ready, digit_count, bus.word_valid, bus.a, bus.b, bus.c, bus.d} !== {2'b10, 3'd0, 1'b0, 16'h9999}) begin
         miscompares++;
         $display("FAIL error_flag: err=%b rdy=%b cnt=%0d wv=%b abcd=%h, required err=1 rdy=0 cnt=0 wv=0 abcd=9999",
                  bcd_error, bus.digit_ready, digit_count, bus.word_valid, {bus.a, bus.b, bus.c, bus.d});
      end
      bus.digit_in    = 4'd2;
      bus.digit_valid = 1'b1;
      bus.word_ack    = 1'b1;
      tick();
      tick();
      bus.digit_valid = 1'b0;
      bus.word_ack    = 1'b0;
      vectors++;
      if ({bcd_error, bus.digit_ready, digit_count, bus.word_valid} !== {2'b10, 3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL error_sticky: err=%b rdy=%b cnt=%0d wv=%b, required err=1 rdy=0 cnt=0 wv=0",
                  bcd_error, bus.digit_ready, digit_count, bus.word_valid);
      end
      do_clear();
      vectors++;
      if ({bcd_error, bus.digit_ready, bus.a, bus.b, bus.c, bus.d} !== {2'b01, 16'h9999}) begin
         miscompares++;
         $display("FAIL error_clear: err=%b rdy=%b abcd=%h, required err=0 rdy=1 abcd=9999",
                  bcd_error, bus.digit_ready, {bus.a, bus.b, bus.c, bus.d});
      end
      send(4'd0);
      send(4'd0);
      send(4'd0);
      send(4'd3);
      vectors++;
      if ({bus.word_valid, bus.a, bus.b, bus.c, bus.d} !== {1'b1, 16'h0003}) begin
         miscompares++;
         $display("FAIL error_recover: wv=%b abcd=%h, required wv=1 abcd=0003",
                  bus.word_valid, {bus.a, bus.b, bus.c, bus.d});
      end
      ack();
   endtask

   task automatic test_clear_collision();
      for (int i = 0; i < 3; i++) send(4'($urandom_range(0, 9)));
      vectors++;
      if (digit_count !== 3'd3) begin
         miscompares++;
         $display("FAIL collision_pre: digit_count=%0d, required 3", digit_count);
      end
      clear           = 1'b1;
      bus.digit_in    = 4'd8;
      bus.digit_valid = 1'b1;
      tick();
      clear           = 1'b0;
      bus.digit_valid = 1'b0;
      m_part.delete();
      tick();
      tick();
      vectors++;
      if ({digit_count, bus.word_valid, bus.digit_ready, bus.a, bus.b, bus.c, bus.d} !== {3'd0, 2'b01, 16'h0003}) begin
         miscompares++;
         $display("FAIL collision_drop: cnt=%0d wv=%b rdy=%b abcd=%h, required cnt=0 wv=0 rdy=1 abcd=0003",
                  digit_count, bus.word_valid, bus.digit_ready, {bus.a, bus.b, bus.c, bus.d});
      end
      for (int i = 0; i < 4; i++) send(4'($urandom_range(0, 9)));
      vectors++;
      if ({bus.word_valid, bus.a, bus.b, bus.c, bus.d} !== {1'b1, m_word}) begin
         miscompares++;
         $display("FAIL collision_fresh: wv=%b abcd=%h, required wv=1 abcd=%h",
                  bus.word_valid, {bus.a, bus.b, bus.c, bus.d}, m_word);
      end
      ack();
   endtask

   task automatic test_reset_midword();
      send(4'd5);
      send(4'd6);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({bus.a, bus.b, bus.c, bus.d, bus.word_valid, bcd_error, digit_count, timeout, bus.digit_ready} !== '0) begin
         miscompares++;
         $display("FAIL midword_reset: abcd=%h wv=%b err=%b cnt=%0d to=%b rdy=%b, required all 0",
                  {bus.a, bus.b, bus.c, bus.d}, bus.word_valid, bcd_error, digit_count, timeout, bus.digit_ready);
      end
      tick();
      rst_n = 1'b1;
      vectors++;
      if (bus.digit_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midword_ready_low: digit_ready=%b, required 0", bus.digit_ready);
      end
      tick();
      vectors++;
      if ({bus.digit_ready, digit_count} !== {1'b1, 3'd0}) begin
         miscompares++;
         $display("FAIL midword_ready_rise: rdy=%b cnt=%0d, required rdy=1 cnt=0", bus.digit_ready, digit_count);
      end
   endtask

`ifdef BCD_TIMEOUT_EN
   task automatic test_timeout();
      send(4'd2);
      send(4'd7);
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++;
         if ({timeout, digit_count} !== ((i == 10) ? {1'b1, 3'd0} : {1'b0, 3'd2})) begin
            miscompares++;
            $display("FAIL timeout_expire: idle %0d to=%b cnt=%0d, required to=%b cnt=%0d",
                     i, timeout, digit_count, i == 10, (i == 10) ? 0 : 2);
         end
      end
      m_part.delete();
      tick();
      vectors++;
      if (timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_pulse_width: timeout=%b, required 0", timeout);
      end
      send(4'd1);
      repeat (8) tick();
      send(4'd4);
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++;
         if ({timeout, digit_count} !== ((i == 10) ? {1'b1, 3'd0} : {1'b0, 3'd2})) begin
            miscompares++;
            $display("FAIL timeout_restart: idle %0d to=%b cnt=%0d, required to=%b cnt=%0d",
                     i, timeout, digit_count, i == 10, (i == 10) ? 0 : 2);
         end
      end
      m_part.delete();
      tick();
   endtask
`else
   task automatic test_timeout();
      send(4'd2);
      send(4'd7);
      for (int i = 0; i < 15; i++) begin
         tick();
         vectors++;
         if ({timeout, digit_count} !== {1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL no_timeout: idle %0d to=%b cnt=%0d, required to=0 cnt=2", i, timeout, digit_count);
         end
      end
      do_clear();
   endtask
`endif

   task automatic test_random();
      int r;
      for (int n = 0; n < 400; n++) begin
         if (m_err) begin
            do_clear();
         end else if (m_wv) begin
            repeat ($urandom_range(0, 3)) tick();
            ack();
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 5) do_clear();
            else if (r < 15) send(4'($urandom_range(10, 15)));
            else send(4'($urandom_range(0, 9)));
         end
         vectors++;
         if ({bus.a, bus.b, bus.c, bus.d} !== m_word || bus.word_valid !== m_wv || bcd_error !== m_err ||
             digit_count !== 3'(m_part.size()) || bus.digit_ready !== (!m_wv && !m_err) || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL random_step %0d: abcd=%h wv=%b err=%b cnt=%0d rdy=%b to=%b, required abcd=%h wv=%b err=%b cnt=%0d rdy=%b to=0",
                     n, {bus.a, bus.b, bus.c, bus.d}, bus.word_valid, bcd_error, digit_count, bus.digit_ready, timeout,
                     m_word, m_wv, m_err, m_part.size(), !m_wv && !m_err);
         end
      end
   endtask

   initial begin
      bus.digit_in    = '0;
      bus.digit_valid = 1'b0;
      bus.word_ack    = 1'b0;
      model_reset();
      test_reset();
      test_word_assembly();
      test_backpressure();
      test_bcd_error();
      test_clear_collision();
      test_reset_midword();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
